// File: rtl/irq_prio_ctrl.sv
// Clocked interrupt priority controller: latches per-bus/per-channel requests,
// arbitrates fixed priority across buses (fixed or round-robin within a bus), valid/ready output.
module irq_prio_ctrl #(
  parameter int NUM_CH  = 9,
  parameter int NUM_BUS = 3,
  parameter int RR_MODE = 0,
  localparam int IDW = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1,
  localparam int BW  = (NUM_BUS > 1) ? $clog2(NUM_BUS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_BUS*NUM_CH-1:0]  req_i,
  input  logic [NUM_CH-1:0]          en_i,
  output logic                       irq_valid_o,
  input  logic                       irq_ready_i,
  output logic [BW-1:0]              irq_bus_o,
  output logic [IDW-1:0]             irq_id_o,
  output logic [NUM_BUS-1:0]         bus_active_o,
  output logic [NUM_CH-1:0]          ovf_o,
  input  logic [NUM_CH-1:0]          ovf_clr_i
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARB     = 2'd1,
    S_PRESENT = 2'd2
  } state_e;

  state_e                            state_q, state_d;
  logic [NUM_BUS-1:0][NUM_CH-1:0]    pend_q, pend_d;
  logic [NUM_BUS-1:0][IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0]                 ovf_q, ovf_d;
  logic [NUM_BUS-1:0]                bus_active_q, bus_active_d;
  logic [BW-1:0]                     bus_q, bus_d;
  logic [IDW-1:0]                    id_q, id_d;
  logic                              valid_q, valid_d;

  logic [NUM_BUS-1:0][NUM_CH-1:0]    req_s, clr_s, eff_s;
  logic [NUM_CH-1:0]                 ovf_set_s;
  logic                              hs_s, any_eff_s, sel_found_s;
  logic [BW-1:0]                     sel_bus_s;
  logic [IDW-1:0]                    sel_id_s;

  // First set bit of vec, scanning upward from ptr (round-robin) or from 0 (fixed).
  function automatic logic [IDW-1:0] pick_id(input logic [NUM_CH-1:0] vec,
                                             input logic [IDW-1:0]    ptr);
    logic           found;
    logic [IDW-1:0] res;
    logic [IDW-1:0] idx;
    int             j;
    found = 1'b0;
    res   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (RR_MODE != 0) begin
        j = int'(ptr) + k;
      end else begin
        j = k;
      end
      if (j >= NUM_CH) begin
        j = j - NUM_CH;
      end else begin
        j = j;
      end
      idx = IDW'(j);
      if (!found && vec[idx]) begin
        found = 1'b1;
        res   = idx;
      end else begin
        found = found;
      end
    end
    return res;
  endfunction

  assign req_s = req_i;
  assign hs_s  = valid_q & irq_ready_i;

  // One-hot clear of the entry accepted on this edge.
  always_comb begin
    clr_s = '0;
    if (hs_s) begin
      clr_s[bus_q][id_q] = 1'b1;
    end else begin
      clr_s = '0;
    end
  end

  // Pending update (set beats clear), overflow detection and per-bus activity.
  always_comb begin
    pend_d       = '0;
    eff_s        = '0;
    ovf_set_s    = '0;
    bus_active_d = '0;
    for (int b = 0; b < NUM_BUS; b++) begin
      pend_d[b]       = (pend_q[b] & en_i & ~clr_s[b]) | (req_s[b] & en_i);
      eff_s[b]        = pend_q[b] & en_i;
      ovf_set_s       = ovf_set_s | (req_s[b] & en_i & pend_q[b] & ~clr_s[b]);
      bus_active_d[b] = |pend_q[b];
    end
    ovf_d     = (ovf_q & ~ovf_clr_i) | ovf_set_s;
    any_eff_s = |eff_s;
  end

  // Fixed priority across buses: the lowest-index bus with an enabled pending entry wins.
  always_comb begin
    sel_found_s = 1'b0;
    sel_bus_s   = '0;
    sel_id_s    = '0;
    for (int b = 0; b < NUM_BUS; b++) begin
      if (!sel_found_s && (|eff_s[b])) begin
        sel_found_s = 1'b1;
        sel_bus_s   = BW'(b);
        sel_id_s    = pick_id(eff_s[b], rr_ptr_q[b]);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Handshake FSM next-state and grant registers.
  always_comb begin
    state_d  = state_q;
    bus_d    = bus_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (any_eff_s) begin
          state_d = S_ARB;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARB: begin
        if (sel_found_s) begin
          state_d = S_PRESENT;
          bus_d   = sel_bus_s;
          id_d    = sel_id_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRESENT: begin
        if (hs_s) begin
          if (RR_MODE != 0) begin
            if (id_q == IDW'(NUM_CH - 1)) begin
              rr_ptr_d[bus_q] = '0;
            end else begin
              rr_ptr_d[bus_q] = id_q + IDW'(1);
            end
          end else begin
            rr_ptr_d = rr_ptr_q;
          end
          if (|pend_d) begin
            state_d = S_ARB;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_PRESENT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    valid_d = (state_d == S_PRESENT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pend_q       <= '0;
      rr_ptr_q     <= '0;
      ovf_q        <= '0;
      bus_active_q <= '0;
      bus_q        <= '0;
      id_q         <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      rr_ptr_q     <= rr_ptr_d;
      ovf_q        <= ovf_d;
      bus_active_q <= bus_active_d;
      bus_q        <= bus_d;
      id_q         <= id_d;
      valid_q      <= valid_d;
    end
  end

  assign irq_valid_o  = valid_q;
  assign irq_bus_o    = bus_q;
  assign irq_id_o     = id_q;
  assign bus_active_o = bus_active_q;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Scoreboard bench: fixed-priority and round-robin instances share stimulus; grants
// are checked by per-instance monitors against queued expectations.
module tb_irq_prio_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [26:0] req = '0;
  logic [8:0]  en = '1;
  logic        ready = 1'b0;
  logic [8:0]  ovf_clr = '0;

  logic        valid0, valid1;
  logic [1:0]  bus0, bus1;
  logic [3:0]  id0, id1;
  logic [2:0]  act0, act1;
  logic [8:0]  ovf0, ovf1;

  logic [5:0]  q0[$];
  logic [5:0]  q1[$];
  logic [5:0]  e0, e1;
  int          tests = 0;
  int          fails = 0;
  int          hs0 = 0;
  int          hs1 = 0;
  int          base0, base1;

  irq_prio_ctrl #(.NUM_CH(9), .NUM_BUS(3), .RR_MODE(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .en_i(en),
    .irq_valid_o(valid0), .irq_ready_i(ready), .irq_bus_o(bus0), .irq_id_o(id0),
    .bus_active_o(act0), .ovf_o(ovf0), .ovf_clr_i(ovf_clr)
  );

  irq_prio_ctrl #(.NUM_CH(9), .NUM_BUS(3), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req_i(req), .en_i(en),
    .irq_valid_o(valid1), .irq_ready_i(ready), .irq_bus_o(bus1), .irq_id_o(id1),
    .bus_active_o(act1), .ovf_o(ovf1), .ovf_clr_i(ovf_clr)
  );

  always #5 clk = ~clk;

  // Monitor for the fixed-priority instance.
  always @(negedge clk) begin
    if (rst_n && valid0 && ready) begin
      hs0++;
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL grant_fixed: got bus=%0d id=%0d, required no grant", bus0, id0);
      end else begin
        e0 = q0.pop_front();
        if ({bus0, id0} !== e0) begin
          fails++;
          $display("FAIL grant_fixed: got bus=%0d id=%0d, required bus=%0d id=%0d",
                   bus0, id0, e0[5:4], e0[3:0]);
        end
      end
    end
  end

  // Monitor for the round-robin instance.
  always @(negedge clk) begin
    if (rst_n && valid1 && ready) begin
      hs1++;
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL grant_rr: got bus=%0d id=%0d, required no grant", bus1, id1);
      end else begin
        e1 = q1.pop_front();
        if ({bus1, id1} !== e1) begin
          fails++;
          $display("FAIL grant_rr: got bus=%0d id=%0d, required bus=%0d id=%0d",
                   bus1, id1, e1[5:4], e1[3:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_both(input logic [5:0] e);
    q0.push_back(e);
    q1.push_back(e);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = '0;
    ready   = 1'b0;
    ovf_clr = '0;
    en      = '1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    chk("rst_valid", {31'd0, valid0}, 32'd0);
    chk("rst_bus", {30'd0, bus0}, 32'd0);
    chk("rst_id", {28'd0, id0}, 32'd0);
    chk("rst_active", {29'd0, act0}, 32'd0);
    chk("rst_ovf", {23'd0, ovf0}, 32'd0);

    // Single request bus0/ch4: three-edge latency.
    req = 27'h10; push_both(6'h04);
    step();
    req = '0;
    chk("lat_e1_valid", {31'd0, valid0}, 32'd0);
    step();
    chk("lat_e2_valid", {31'd0, valid0}, 32'd0);
    chk("lat_e2_active", {29'd0, act0}, 32'd1);
    step();
    chk("lat_e3_valid", {31'd0, valid0}, 32'd1);
    chk("lat_e3_bus", {30'd0, bus0}, 32'd0);
    chk("lat_e3_id", {28'd0, id0}, 32'd4);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("acc_valid_low", {31'd0, valid0}, 32'd0);
    step();
    step();
    chk("acc_active_clear", {29'd0, act0}, 32'd0);

    // Bus priority: bus1/ch7 beats bus2/ch0.
    req = 27'h5_0000; push_both(6'h17); push_both(6'h20);
    step();
    req = '0;
    step();
    step();
    chk("prio_first_bus", {30'd0, bus0}, 32'd1);
    chk("prio_first_id", {28'd0, id0}, 32'd7);
    ready = 1'b1;
    step();
    chk("prio_gap_valid", {31'd0, valid0}, 32'd0);
    step();
    chk("prio_second_valid", {31'd0, valid0}, 32'd1);
    chk("prio_second_bus", {30'd0, bus0}, 32'd2);
    step();
    ready = 1'b0;

    // No preemption while presenting bus1/ch2.
    req = 27'h800; push_both(6'h12); push_both(6'h00);
    step();
    req = '0;
    step();
    step();
    req = 27'h1;
    step();
    req = '0;
    chk("hold_bus", {30'd0, bus0}, 32'd1);
    chk("hold_id", {28'd0, id0}, 32'd2);
    step();
    chk("hold_valid", {31'd0, valid0}, 32'd1);
    chk("hold_id2", {28'd0, id0}, 32'd2);
    ready = 1'b1;
    step();
    step();
    chk("next_bus0", {30'd0, bus0}, 32'd0);
    chk("next_id0", {28'd0, id0}, 32'd0);
    step();
    ready = 1'b0;

    // Overflow on re-request; set beats clear; clear pulse.
    req = 27'h20; push_both(6'h05);
    step();
    step();
    chk("ovf_set", {23'd0, ovf0}, 32'h20);
    ovf_clr = 9'h20;
    step();
    req = '0; ovf_clr = '0;
    chk("ovf_set_beats_clr", {23'd0, ovf0}, 32'h20);
    ready = 1'b1;
    step();
    ready = 1'b0; ovf_clr = 9'h20;
    step();
    ovf_clr = '0;
    chk("ovf_cleared", {23'd0, ovf0}, 32'h0);

    // Enable dropped while pending in IDLE, then in ARB.
    req = 27'h8;
    step();
    req = '0; en = 9'h1F7;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en_idle_novalid", {31'd0, valid0}, 32'd0);
    end
    chk("en_idle_active", {29'd0, act0}, 32'd0);
    en = '1; req = 27'h8;
    step();
    req = '0;
    step();
    en = 9'h1F7;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("en_arb_novalid", {31'd0, valid0}, 32'd0);
    end
    en = '1;

    // Reset during PRESENT drops the winner.
    req = 27'h400_0000;
    step();
    step();
    req = '0;
    step();
    chk("pre_rst_valid", {31'd0, valid0}, 32'd1);
    chk("pre_rst_ovf", {23'd0, ovf0}, 32'h100);
    rst_n = 1'b0;
    step();
    chk("midrst_valid", {31'd0, valid0}, 32'd0);
    chk("midrst_bus", {30'd0, bus0}, 32'd0);
    chk("midrst_id", {28'd0, id0}, 32'd0);
    chk("midrst_active", {29'd0, act0}, 32'd0);
    chk("midrst_ovf", {23'd0, ovf0}, 32'd0);
    chk("midrst_valid_rr", {31'd0, valid1}, 32'd0);

    // Fixed vs round-robin with ch1, ch3, ch8 of bus0 held.
    do_reset();
    base0 = hs0; base1 = hs1;
    q0.push_back(6'h01); q0.push_back(6'h01); q0.push_back(6'h01); q0.push_back(6'h01);
    q1.push_back(6'h01); q1.push_back(6'h03); q1.push_back(6'h08); q1.push_back(6'h01);
    req = 27'h10A; ready = 1'b1;
    begin
      int n = 0;
      while (hs0 < base0 + 4 && n < 40) begin
        step();
        n++;
      end
    end
    ready = 1'b0; req = '0;
    chk("rr_count_fixed", hs0 - base0, 32'd4);
    chk("rr_count_rr", hs1 - base1, 32'd4);
    do_reset();
    step();

    chk("queue_fixed_empty", q0.size(), 32'd0);
    chk("queue_rr_empty", q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
